// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-detecting, prioritised interrupt sequencer for the core
// Optional SERVICE watchdog compiled in with INTC_TIMEOUT_EN.
`timescale 1ns/1ps

module interrupt_controller #(
    parameter int          NUM_SRC        = 4,
    parameter logic [31:0] VEC_BASE       = 32'h0000_0010,
    parameter int          DRAIN_CYCLES   = 3,
    parameter int          TIMEOUT_CYCLES = 1024,
    localparam int         ID_W           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               branch_pending,
    input  logic               rti_done,
    output logic               interrupt,
    output logic [31:0]        vec_addr,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic               in_service,
    output logic [ID_W-1:0]    active_id,
    output logic               service_timeout
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    generate
        if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
            $error("interrupt_controller: NUM_SRC out of range");
        end
        if (DRAIN_CYCLES < 1) begin : g_bad_drain
            $error("interrupt_controller: DRAIN_CYCLES must be at least 1");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("interrupt_controller: TIMEOUT_CYCLES must fit the 16-bit watchdog");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_FIRE,
        S_SERVICE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [NUM_SRC-1:0] r_irq_req_d;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_elig;
    logic [ID_W-1:0]    r_active_id;
    logic [ID_W-1:0]    w_prio_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_vec_addr;
    logic               w_load;
    logic               w_timeout;

    assign w_rise = irq_req & ~r_irq_req_d;
    assign w_elig = r_pending & ~irq_mask;
    assign w_clr  = (r_state == S_FIRE) ?
                    ({{(NUM_SRC-1){1'b0}}, 1'b1} << r_active_id) : '0;

    // Scanning downwards leaves the lowest eligible index as the winner.
    always_comb begin
        w_prio_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_prio_id = ID_W'(i);
            end
        end
    end

`ifdef INTC_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (reset || r_state != S_SERVICE) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == S_SERVICE) && !rti_done &&
                       (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_elig != '0) begin
                    if (branch_pending) begin
                        w_next = S_WAIT;
                    end else begin
                        w_load = 1'b1;
                        w_next = S_DRAIN;
                    end
                end
            end
            S_WAIT: begin
                if (!branch_pending) begin
                    if (w_elig != '0) begin
                        w_load = 1'b1;
                        w_next = S_DRAIN;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (r_cnt == '0) begin
                    w_next = S_FIRE;
                end
            end
            S_FIRE: begin
                w_next = S_SERVICE;
            end
            S_SERVICE: begin
                if (rti_done || w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The delay register keeps sampling through reset so a request level held
    // across reset is not mistaken for a fresh rising edge afterwards.
    always_ff @(posedge clk) begin
        r_irq_req_d <= irq_req;
        if (reset) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_cnt       <= '0;
            r_active_id <= '0;
            r_vec_addr  <= '0;
        end else begin
            r_state   <= w_next;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_load) begin
                r_active_id <= w_prio_id;
                r_cnt       <= CNT_W'(DRAIN_CYCLES - 1);
            end else if (r_state == S_DRAIN && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == S_DRAIN && w_next == S_FIRE) begin
                r_vec_addr <= VEC_BASE + (32'(r_active_id) << 1);
            end
        end
    end

    assign interrupt       = (r_state == S_FIRE);
    assign irq_ack         = w_clr;
    assign in_service      = (r_state == S_FIRE) || (r_state == S_SERVICE);
    assign active_id       = r_active_id;
    assign vec_addr        = r_vec_addr;
    assign service_timeout = w_timeout;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed self-checking bench for interrupt_controller
`timescale 1ns/1ps

module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_req;
    logic [3:0]  irq_mask;
    logic        branch_pending;
    logic        rti_done;
    logic        interrupt;
    logic [31:0] vec_addr;
    logic [3:0]  irq_ack;
    logic        in_service;
    logic [1:0]  active_id;
    logic        service_timeout;

    int n_pass  = 0;
    int n_total = 0;
    int n_seen;
    int n_bad;

    interrupt_controller #(
        .NUM_SRC        (4),
        .VEC_BASE       (32'h0000_0010),
        .DRAIN_CYCLES   (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .irq_req         (irq_req),
        .irq_mask        (irq_mask),
        .branch_pending  (branch_pending),
        .rti_done        (rti_done),
        .interrupt       (interrupt),
        .vec_addr        (vec_addr),
        .irq_ack         (irq_ack),
        .in_service      (in_service),
        .active_id       (active_id),
        .service_timeout (service_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_fire(input string tag, input logic [3:0] ack, input logic [31:0] vec,
                            input logic [1:0] id);
        chk({tag, "_int"}, 32'(interrupt), 32'd1);
        chk({tag, "_ack"}, 32'(irq_ack), 32'(ack));
        chk({tag, "_vec"}, vec_addr, vec);
        chk({tag, "_id"},  32'(active_id), 32'(id));
        chk({tag, "_svc"}, 32'(in_service), 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_int"}, 32'(interrupt), 32'd0);
        chk({tag, "_ack"}, 32'(irq_ack), 32'd0);
        chk({tag, "_vec"}, vec_addr, 32'd0);
        chk({tag, "_id"},  32'(active_id), 32'd0);
        chk({tag, "_svc"}, 32'(in_service), 32'd0);
        chk({tag, "_to"},  32'(service_timeout), 32'd0);
    endtask

    task automatic finish_service();
        rti_done = 1'b1;
        tick(1);
        rti_done = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        irq_req        = 4'b0000;
        irq_mask       = 4'b0000;
        branch_pending = 1'b0;
        rti_done       = 1'b0;
        tick(2);
        chk_idle_outputs("reset");
        reset = 1'b0;
        tick(1);

        // Single source, no branch: fire in the cycle after edge E4.
        irq_req = 4'b0100;
        tick(1);
        chk("t1_e0_int", 32'(interrupt), 32'd0);
        tick(3);
        chk("t1_e3_int", 32'(interrupt), 32'd0);
        chk("t1_e3_svc", 32'(in_service), 32'd0);
        tick(1);
        chk_fire("t1_fire", 4'b0100, 32'h14, 2'd2);
        tick(1);
        chk("t1_svc_int", 32'(interrupt), 32'd0);
        chk("t1_svc_ack", 32'(irq_ack), 32'd0);
        chk("t1_svc_vec", vec_addr, 32'h14);
        chk("t1_svc_svc", 32'(in_service), 32'd1);
        finish_service();
        chk("t1_rti_svc", 32'(in_service), 32'd0);
        irq_req = 4'b0000;
        tick(2);
        rti_done = 1'b1;
        tick(1);
        rti_done = 1'b0;
        chk("t1_stray_rti", 32'({interrupt, in_service}), 32'd0);

        // Two simultaneous sources: lowest index first, then the other.
        irq_req = 4'b1010;
        tick(5);
        chk_fire("t2_first", 4'b0010, 32'h12, 2'd1);
        tick(1);
        finish_service();
        chk("t2_rti_svc", 32'(in_service), 32'd0);
        tick(3);
        chk("t2_gap_int", 32'(interrupt), 32'd0);
        tick(1);
        chk_fire("t2_second", 4'b1000, 32'h16, 2'd3);
        tick(1);
        finish_service();
        irq_req = 4'b0000;
        tick(2);

        // Masked source stays pending and fires once unmasked.
        irq_mask = 4'b0001;
        irq_req  = 4'b0001;
        tick(1);
        n_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n_seen += int'(interrupt) + int'(in_service);
        end
        chk("t3_masked_quiet", 32'(n_seen), 32'd0);
        irq_mask = 4'b0000;
        tick(3);
        chk("t3_unmask_gap", 32'(interrupt), 32'd0);
        tick(1);
        chk_fire("t3_fire", 4'b0001, 32'h10, 2'd0);
        tick(1);
        finish_service();
        irq_req = 4'b0000;
        tick(2);

        // Branch in flight holds entry; request during SERVICE waits for RTI.
        irq_req = 4'b0010;
        tick(1);
        branch_pending = 1'b1;
        tick(6);
        chk("t4_wait_int", 32'(interrupt), 32'd0);
        chk("t4_wait_svc", 32'(in_service), 32'd0);
        branch_pending = 1'b0;
        tick(3);
        chk("t4_drain_int", 32'(interrupt), 32'd0);
        tick(1);
        chk_fire("t4_fire", 4'b0010, 32'h12, 2'd1);
        tick(1);
        irq_req = 4'b0110;
        n_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_seen += int'(interrupt);
        end
        chk("t4_no_nest", 32'(n_seen), 32'd0);
        chk("t4_still_svc", 32'(in_service), 32'd1);
        finish_service();
        tick(3);
        chk("t4_gap_int", 32'(interrupt), 32'd0);
        tick(1);
        chk_fire("t4_second", 4'b0100, 32'h14, 2'd2);
        tick(1);
        finish_service();
        irq_req = 4'b0000;
        tick(2);

        // Reset during DRAIN discards the latched id and all pending bits.
        irq_req = 4'b0101;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_idle_outputs("t5_reset");
        n_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_seen += int'(interrupt) + int'(in_service);
        end
        chk("t5_no_retrigger", 32'(n_seen), 32'd0);
        irq_req = 4'b0001;
        tick(1);
        irq_req = 4'b0101;
        tick(5);
        chk_fire("t5_new_edge", 4'b0100, 32'h14, 2'd2);
        tick(1);
        irq_req = 4'b1101;

`ifdef INTC_TIMEOUT_EN
        tick(6);
        chk("t6_pre_to", 32'(service_timeout), 32'd0);
        chk("t6_pre_svc", 32'(in_service), 32'd1);
        tick(1);
        chk("t6_to_pulse", 32'(service_timeout), 32'd1);
        tick(1);
        chk("t6_post_to", 32'(service_timeout), 32'd0);
        chk("t6_post_svc", 32'(in_service), 32'd0);
        tick(3);
        chk("t6_gap_int", 32'(interrupt), 32'd0);
        tick(1);
        chk_fire("t6_next", 4'b1000, 32'h16, 2'd3);
        tick(1);
        finish_service();
`else
        n_bad = 0;
        for (int i = 0; i < 11; i++) begin
            tick(1);
            n_bad += int'(service_timeout) + int'(!in_service);
        end
        chk("t6_no_timeout", 32'(n_bad), 32'd0);
        finish_service();
        tick(3);
        chk("t6_gap_int", 32'(interrupt), 32'd0);
        tick(1);
        chk_fire("t6_next", 4'b1000, 32'h16, 2'd3);
        tick(1);
        finish_service();
`endif
        irq_req = 4'b0000;
        tick(2);
        chk("end_svc", 32'(in_service), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
